alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter MULDIV_WAIT, default 4: EXEC-state cycles for MUL/DIV, legal range 1..15.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to run one ALU operation; sampled only in IDLE.
REQ-005 SHALL have port opcode, input, 4, operation code: 0 AND, 1 OR, 2 NEG, 3 NOT, 4 SUB, 5 ADD, 6 MUL, 7 ROR, 8 ROL, 9 DIV, 10 SHR, 11 SHL, 12 SHRA; 13..15 illegal.
REQ-006 SHALL have port Yin, output, 1, load-enable to the Y operand register.
REQ-007 SHALL have port op_sel, output, 13, one-hot ALU control in the opcode order above (bit 0 = AND ... bit 12 = SHRA).
REQ-008 SHALL have port Zin, output, 1, capture-enable for the Z result pair (resultLo/resultHi).
REQ-009 SHALL have port hi_valid, output, 1, high with Zin when the op is MUL or DIV.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port illegal, output, 1, one-cycle pulse for a rejected opcode.

Function
REQ-013 SHALL implement FSM states IDLE, LOADY, EXEC, CAPT.
REQ-014 In IDLE with start=1 and a legal opcode, SHALL latch opcode and go to LOADY next cycle.
REQ-015 In IDLE with start=1 and opcode 13..15, SHALL stay in IDLE and pulse illegal for exactly one cycle on the next cycle.
REQ-016 LOADY SHALL last one cycle with Yin=1 and op_sel=0, then go to EXEC.
REQ-017 EXEC SHALL drive op_sel one-hot from the latched opcode, never from the live opcode input.
REQ-018 EXEC SHALL last 1 cycle for non-MUL/DIV ops and MULDIV_WAIT cycles for MUL/DIV, counted by a 4-bit down-counter loaded on entry to EXEC.
REQ-019 CAPT SHALL last one cycle: op_sel held, Zin=1, done=1, hi_valid=1 only for MUL/DIV; next state IDLE.
REQ-020 Latency SHALL be: start accepted at cycle 0 -> Zin at cycle 3 for single-cycle ops, at cycle 2+MULDIV_WAIT for MUL/DIV.
REQ-021 start while busy=1 SHALL be ignored; the request is not queued.
REQ-022 start asserted in the CAPT cycle SHALL be ignored; a new op needs start in IDLE, so back-to-back ops are spaced one IDLE cycle apart.
REQ-023 op_sel SHALL be all zeros in IDLE and LOADY, and never have more than one bit set.
REQ-024 Yin, Zin, done and illegal SHALL never be asserted in the same cycle as each other, except Zin with done.

Reset
REQ-025 clear=0 SHALL force state IDLE, counter 0, latched opcode 0, and Yin, op_sel, Zin, hi_valid, busy, done and illegal all to 0, immediately and without waiting for a clock edge.
REQ-026 clear asserted mid-operation SHALL abandon the operation with no Zin or done pulse.
REQ-027 After clear is released, the first accepted start SHALL be sampled on the first rising edge with clear=1.

Configuration
REQ-028 Macro ALU_SEQ_ABORT_EN: when defined, SHALL add input abort (1) and output aborted (1).
REQ-029 With ALU_SEQ_ABORT_EN defined, abort=1 in LOADY or EXEC SHALL return to IDLE on the next cycle with no Zin or done, and pulse aborted for one cycle.
REQ-030 With ALU_SEQ_ABORT_EN defined, abort=1 in CAPT or IDLE SHALL have no effect.
REQ-031 Without ALU_SEQ_ABORT_EN, the abort and aborted ports SHALL not exist and behaviour SHALL be exactly REQ-013..REQ-027.

Verification
REQ-032 ADD case: start=1, opcode=5 at cycle 0 -> Yin at cycle 1; op_sel=13'h0020 at cycles 2-3; Zin=done=1 at cycle 3; hi_valid=0.
REQ-033 MUL case, MULDIV_WAIT=4: opcode=6 -> op_sel=13'h0040 at cycles 2-6; Zin=hi_valid=done=1 at cycle 6; busy low at cycle 7.
REQ-034 Illegal opcode: start with opcode=14 -> illegal=1 for one cycle; busy, Yin and Zin stay 0.
REQ-035 Busy and change: second start with opcode=9 during EXEC of SHL -> ignored; op_sel stays 13'h0800 through CAPT.
REQ-036 Clear mid-op: clear=0 during EXEC of DIV -> all outputs 0 asynchronously; no done afterwards.
REQ-037 ALU_SEQ_ABORT_EN defined: abort=1 at cycle 3 of a MUL -> aborted pulse at cycle 4, IDLE, no Zin.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - IDLE/LOADY/EXEC/CAPT control sequencer for a one-hot ALU datapath.
// Optional abort/aborted port pair is built only when ALU_SEQ_ABORT_EN is defined.
module alu_op_sequencer #(
  parameter int MULDIV_WAIT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [3:0]  opcode,
`ifdef ALU_SEQ_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  output logic        Yin,
  output logic [12:0] op_sel,
  output logic        Zin,
  output logic        hi_valid,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, LOADY, EXEC, CAPT} state_t;

  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_LAST = 4'd12;
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_WAIT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       is_muldiv;

  assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

`ifdef ALU_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  logic abort_hit;

  // Abort only bites while the operation can still be dropped without a Z write.
  assign abort_hit = abort && ((state_q == LOADY) || (state_q == EXEC));
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 4'd0;
      illegal_q <= 1'b0;
`ifdef ALU_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
`ifdef ALU_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (opcode <= OP_LAST) begin
            op_d    = opcode;
            state_d = LOADY;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      LOADY: begin
        state_d = EXEC;
        cnt_d   = is_muldiv ? MD_LOAD : 4'd0;
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef ALU_SEQ_ABORT_EN
    aborted_d = 1'b0;
    if (abort_hit) begin
      state_d   = IDLE;
      cnt_d     = 4'd0;
      aborted_d = 1'b1;
    end
`endif
  end

  // op_sel decodes the latched opcode so a changing opcode input cannot glitch the ALU.
  always_comb begin
    Yin      = (state_q == LOADY);
    busy     = (state_q != IDLE);
    op_sel   = 13'd0;
    Zin      = 1'b0;
    done     = 1'b0;
    hi_valid = 1'b0;
    illegal  = illegal_q;
    if ((state_q == EXEC) || (state_q == CAPT)) begin
      op_sel = 13'd1 << op_q;
    end
    if (state_q == CAPT) begin
      Zin      = 1'b1;
      done     = 1'b1;
      hi_valid = is_muldiv;
    end
  end

`ifdef ALU_SEQ_ABORT_EN
  assign aborted = aborted_q;
`endif

endmodule
